// File: rtl/hpdmc_phy_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hpdmc_phy_pkg
// Description : Shared state encoding and framing lengths for the HPDMC DDR PHY.
// Revision    : 1.0 - initial release
// ============================================================================
package hpdmc_phy_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PRE  = 2'd1,
    ST_DATA = 2'd2,
    ST_POST = 2'd3
  } state_t;

  localparam int PRE_LEN  = 1;
  localparam int POST_LEN = 1;

endpackage
`default_nettype wire

// File: rtl/hpdmc_oddr_lane.sv
`default_nettype none
// ============================================================================
// Module      : hpdmc_oddr_lane
// Description : One-bit behavioural DDR output flop; swap in a vendor ODDR here.
// Revision    : 1.0 - initial release
// ============================================================================
module hpdmc_oddr_lane (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic ce,
  input  logic d0,
  input  logic d1,
  output logic q
);

  logic rise_q;
  logic fall_q;

  // Both halves are captured on the rising edge; a dropped ce zeroes the pad.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else if (ce) begin
      rise_q <= d0;
      fall_q <= d1;
    end else begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end
  end

  assign q = sys_clk ? rise_q : fall_q;

endmodule
`default_nettype wire

// File: rtl/hpdmc_oddr_bank.sv
`default_nettype none
// ============================================================================
// Module      : hpdmc_oddr_bank
// Description : WIDTH-lane DDR write-data bank with preamble/postamble OE framing.
//               Optional data mask lanes when HPDMC_ODDR_MASK_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module hpdmc_oddr_bank
  import hpdmc_phy_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int BURST = 4
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             wr_start,
  output logic             wr_ready,
  output logic             d_ack,
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
`ifdef HPDMC_ODDR_MASK_EN
  input  logic [WIDTH/8-1:0] m0,
  input  logic [WIDTH/8-1:0] m1,
  output logic [WIDTH/8-1:0] dm,
`endif
  output logic [WIDTH-1:0] q,
  output logic             oe,
  output logic             busy
);

  localparam int            CW   = $clog2(BURST) + 1;
  localparam logic [CW-1:0] LAST = CW'(BURST - 1);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          oe_q;
  logic          cap_en;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: if (wr_start) state_d = ST_PRE;
      ST_PRE: begin
        state_d = ST_DATA;
        cnt_d   = '0;
      end
      ST_DATA: begin
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          state_d = wr_start ? ST_DATA : ST_POST;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_POST: state_d = wr_start ? ST_PRE : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // oe and the lanes both follow the state being entered, keeping them aligned.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      oe_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      oe_q    <= (state_d != ST_IDLE);
    end
  end

  assign cap_en   = (state_d == ST_DATA);
  assign oe       = oe_q;
  assign busy     = (state_q != ST_IDLE);
  assign d_ack    = (state_q == ST_DATA);
  assign wr_ready = sys_rst_n & ((state_q == ST_IDLE) || (state_q == ST_POST) ||
                                 ((state_q == ST_DATA) && (cnt_q == LAST)));

  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    hpdmc_oddr_lane u_lane (
      .sys_clk  (sys_clk),
      .sys_rst_n(sys_rst_n),
      .ce       (cap_en),
      .d0       (d0[i]),
      .d1       (d1[i]),
      .q        (q[i])
    );
  end

`ifdef HPDMC_ODDR_MASK_EN
  for (genvar j = 0; j < WIDTH/8; j++) begin : g_dm
    hpdmc_oddr_lane u_lane (
      .sys_clk  (sys_clk),
      .sys_rst_n(sys_rst_n),
      .ce       (cap_en),
      .d0       (m0[j]),
      .d1       (m1[j]),
      .q        (dm[j])
    );
  end
`else
  // No mask lanes in this build.
`endif

endmodule
`default_nettype wire
